wb_spi_slave: RTL and testbench
===============================

// Module: wb_spi_slave
// PURPOSE
//  SPI responder with a Wishbone register interface: the peer end of the WB SPI flash/MCU master.
//  Lets an external SPI master (MCU or second board) exchange bytes with the CPU.
//  SPI pins are sampled by wb_clk_i through synchronisers; received bytes go to an RX FIFO.
//  Transmit bytes come from a single TX holding register.
// PARAMETERS
//  RX_DEPTH     4     RX FIFO depth in bytes, power of 2, >=2
//  SYNC_STAGES  2     synchroniser flops on sclk_i, mosi_i, ss_n_i (>=2)
//  IDLE_BYTE    8'hFF byte sent when TX holding register is empty
// PORTS
//  wb_clk_i    in   1   system/Wishbone clock, sole clock
//  wb_rst_n_i  in   1   asynchronous reset, active-low
//  wb_adr_i    in   1   0=DATA, 1=STATUS/CTRL
//  wb_dat_i    in   16  write data
//  wb_dat_o    out  16  read data
//  wb_we_i     in   1   write enable
//  wb_sel_i    in   2   byte lanes; [0]=bits 7:0, [1]=bits 15:8
//  wb_stb_i    in   1   strobe
//  wb_cyc_i    in   1   cycle
//  wb_ack_o    out  1   acknowledge
//  sclk_i      in   1   SPI clock from master, idles high
//  mosi_i      in   1   SPI data in
//  ss_n_i      in   1   SPI select, active-low
//  miso_o      out  1   SPI data out
//  miso_oe_o   out  1   miso tri-state enable, 1 while selected
//  irq_o       out  1   interrupt request (see CONFIGURATION)
// BEHAVIOUR
//  Reset: wb_dat_o=0, wb_ack_o=0, miso_o=1, miso_oe_o=0, irq_o=0; FIFO empty, TX empty, flags 0.
//  SPI mode 3 (CPOL=1,CPHA=1), MSB first: mosi sampled on sclk rise, miso changes on sclk fall.
//  sclk_i high and low phases each >=2 wb_clk_i periods (master runs at wb_clk/4).
//  Edges detected on synchronised signals; sampled rise = sync(n)=1 & sync(n-1)=0.
//  States IDLE/ACTIVE: IDLE->ACTIVE on synced ss_n fall; ACTIVE->IDLE on ss_n rise.
//  On entry to ACTIVE: bit counter=0, tx_shift<=TX holding (clears tx_full) or IDLE_BYTE + underrun=1.
//  Each sclk fall in ACTIVE: miso_o<=tx_shift[7], tx_shift<<=1.
//  Each sclk rise: rx_shift<={rx_shift[6:0],mosi}, count++; on 8th rise: push byte, count=0, reload tx_shift.
//  Push when FIFO full: byte dropped, overrun=1 (sticky). Pop+push same cycle when full: both succeed.
//  ss_n rise mid-byte: partial byte discarded, counter cleared, miso_oe_o=0 next cycle, miso_o=1.
//  Sclk edges while IDLE ignored.
//  Wishbone: ack registered, asserted 1 cycle after stb&cyc, held 1 cycle, then low >=1 cycle.
//  Read DATA: wb_dat_o={8'h0, FIFO head}; pops on the ack cycle; empty FIFO reads 0, no pop.
//  Write DATA (sel[0]): TX holding<=wb_dat_i[7:0], tx_full=1; overwrites unsent byte silently.
//  Read STATUS: [0]rx_nempty [1]rx_full [2]overrun [3]tx_empty [4]selected [5]underrun [8]irq_en.
//  Write CTRL: sel[0]: [0]=1 clears overrun, [1]=1 clears underrun; sel[1]: [8]->irq_en.
//  Clear and set of same flag in one cycle: set wins.
// CONFIGURATION
//  Macro WB_SPI_SLAVE_IRQ_EN:
//  Defined: irq_o = irq_en & (rx_nempty | overrun), registered, 1-cycle latency.
//  Undefined: irq_o tied 0, irq_en flop absent, STATUS[8] reads 0, CTRL[8] writes ignored.
// TESTING
//  1 Write DATA=0x5A, master sends 0xC3 -> master receives 0x5A; STATUS[0]=1; DATA read=0x00C3.
//  2 No TX write, master sends 1 byte -> master receives 0xFF; STATUS[5]=1; CTRL write 0x0002 clears it.
//  3 Master sends RX_DEPTH+1 bytes unread -> STATUS[1]=1, [2]=1; reads return first RX_DEPTH bytes in order.
//  4 ss_n raised after 5 bits, then full byte 0x81 -> FIFO holds only 0x81.
//  5 IRQ_EN defined, CTRL=0x0100, 1 byte received -> irq_o=1; DATA read -> irq_o=0 in 2 cycles.
//  6 Reset asserted mid-byte -> all outputs at reset values immediately; next byte received cleanly.

Source files
------------

// File: rtl/wb_spi_slave.sv
// SPI mode-3 responder behind a 16-bit Wishbone register pair (DATA, STATUS/CTRL).
// Optional macro WB_SPI_SLAVE_IRQ_EN adds the irq_en control bit and a registered irq_o.
module wb_spi_slave #(
   parameter int          RX_DEPTH    = 4,
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   input  logic        sclk_i,
   input  logic        mosi_i,
   input  logic        ss_n_i,
   output logic        miso_o,
   output logic        miso_oe_o,
   output logic        irq_o
);
   localparam int AW = $clog2(RX_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
   logic sclk_d, ss_d;
   logic sclk_s, mosi_s, ss_s;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, tx_shift, tx_hold, rx_byte;
   logic tx_full, overrun, underrun;
   logic [7:0] mem [RX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] cnt;
   logic enter, leave, active, sclk_rise_a, sclk_fall_a, byte_done, load_tx;
   logic req, wr, rd, pop, push, tx_wr, ctrl_wr0, fifo_full, nempty;
   logic irq_en_v;
   logic [15:0] status;

   // Idle levels for the synchronisers so reset release never looks like an edge.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         sclk_sync <= '1;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b1;
         ss_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state_q <= IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      enter   = 1'b0;
      leave   = 1'b0;
      case (state_q)
         IDLE:    if (!ss_s && ss_d) begin state_d = ACTIVE; enter = 1'b1; end
         ACTIVE:  if (ss_s && !ss_d) begin state_d = IDLE;   leave = 1'b1; end
         default: state_d = IDLE;
      endcase
   end

   assign active      = (state_q == ACTIVE);
   assign sclk_rise_a = active && !leave && sclk_s && !sclk_d;
   assign sclk_fall_a = active && !leave && !sclk_s && sclk_d;
   assign byte_done   = sclk_rise_a && (bit_cnt == 3'd7);
   assign load_tx     = enter || byte_done;
   assign rx_byte     = {rx_shift[6:0], mosi_s};

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= IDLE_BYTE;
         miso_o   <= 1'b1;
      end else begin
         if (enter || leave) bit_cnt <= '0;
         if (leave) miso_o <= 1'b1;
         if (sclk_fall_a) begin
            miso_o   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
         end
         if (sclk_rise_a) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
         end
         if (load_tx) tx_shift <= tx_full ? tx_hold : IDLE_BYTE;
      end
   end

   assign miso_oe_o = active;

   // Register access is decoded on the edge that raises ack; pops happen there too.
   assign req      = wb_stb_i && wb_cyc_i && !wb_ack_o;
   assign wr       = req && wb_we_i;
   assign rd       = req && !wb_we_i;
   assign pop      = rd && !wb_adr_i && nempty;
   assign tx_wr    = wr && !wb_adr_i && wb_sel_i[0];
   assign ctrl_wr0 = wr && wb_adr_i && wb_sel_i[0];

   assign fifo_full = (cnt == FULL_CNT);
   assign nempty    = (cnt != '0);
   assign push      = byte_done && (!fifo_full || pop);

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // A set in the same cycle as a CTRL clear keeps the flag high.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         tx_hold  <= '0;
         tx_full  <= 1'b0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (tx_wr) tx_hold <= wb_dat_i[7:0];
         if (tx_wr)        tx_full <= 1'b1;
         else if (load_tx) tx_full <= 1'b0;
         overrun  <= (byte_done && fifo_full && !pop) ||
                     (overrun && !(ctrl_wr0 && wb_dat_i[0]));
         underrun <= (load_tx && !tx_full) ||
                     (underrun && !(ctrl_wr0 && wb_dat_i[1]));
      end
   end

   assign status = {7'b0, irq_en_v, 2'b0, underrun, active, !tx_full, overrun, fifo_full, nempty};

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= req;
         if (rd) wb_dat_o <= wb_adr_i ? status : {8'h00, nempty ? mem[rd_ptr] : 8'h00};
      end
   end

`ifdef WB_SPI_SLAVE_IRQ_EN
   logic irq_en;
   logic unused_bits;
   assign unused_bits = ^wb_dat_i[15:9];
   assign irq_en_v = irq_en;
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         irq_en <= 1'b0;
         irq_o  <= 1'b0;
      end else begin
         if (wr && wb_adr_i && wb_sel_i[1]) irq_en <= wb_dat_i[8];
         irq_o <= irq_en && (nempty || overrun);
      end
   end
`else
   logic unused_bits;
   assign unused_bits = ^{wb_dat_i[15:8], wb_sel_i[1]};
   assign irq_en_v = 1'b0;
   assign irq_o    = 1'b0;
`endif
endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed bench for wb_spi_slave: table of single-byte exchanges plus hand sequences
// for overrun, aborted bytes, interrupt and mid-byte reset.
module tb_wb_spi_slave;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_adr, wb_we, wb_stb, wb_cyc, wb_ack;
   logic [15:0] wb_dat_w, wb_dat_r;
   logic [1:0]  wb_sel;
   logic        sclk, mosi, ss_n, miso, miso_oe, irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_spi_slave dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
      .wb_dat_o(wb_dat_r), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb),
      .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack), .sclk_i(sclk), .mosi_i(mosi), .ss_n_i(ss_n),
      .miso_o(miso), .miso_oe_o(miso_oe), .irq_o(irq)
   );

   typedef struct {
      logic [7:0]  tx;
      logic [7:0]  mosi;
      logic [7:0]  exp_miso;
      logic [15:0] exp_stat;
      logic [15:0] exp_rd;
   } vec_t;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wb_xfer(input logic adr, input logic we, input logic [15:0] dat,
                          input logic [1:0] sel, output logic [15:0] rdat);
      logic got;
      got  = 1'b0;
      rdat = 16'hxxxx;
      @(negedge clk);
      wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_sel = sel; wb_stb = 1'b1; wb_cyc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb_ack) begin got = 1'b1; rdat = wb_dat_r; break; end
      end
      @(negedge clk);
      wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL wb_ack timeout adr=%0d we=%0d", adr, we);
      end
   endtask

   task automatic wb_write(input logic adr, input logic [15:0] dat, input logic [1:0] sel);
      logic [15:0] d;
      wb_xfer(adr, 1'b1, dat, sel, d);
   endtask

   task automatic wb_read(input logic adr, output logic [15:0] d);
      wb_xfer(adr, 1'b0, 16'h0, 2'b11, d);
   endtask

   task automatic spi_sel();
      @(negedge clk); ss_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic spi_desel();
      @(negedge clk); ss_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Mode 3 master at wb_clk/8: drive on fall, sample miso just before rise.
   task automatic spi_shift(input logic [7:0] tx, input int n, output logic [7:0] rx);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); sclk = 1'b0; mosi = tx[7-i];
         repeat (4) @(negedge clk);
         r = {r[6:0], miso};
         sclk = 1'b1;
         repeat (3) @(negedge clk);
      end
      rx = r;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [4];
      logic [15:0] d;
      logic [7:0]  r;

      vecs[0] = '{tx: 8'h5A, mosi: 8'hC3, exp_miso: 8'h5A, exp_stat: 16'h0029, exp_rd: 16'h00C3};
      vecs[1] = '{tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_stat: 16'h0029, exp_rd: 16'h00FF};
      vecs[2] = '{tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_stat: 16'h0029, exp_rd: 16'h003C};
      vecs[3] = '{tx: 8'h81, mosi: 8'h7E, exp_miso: 8'h81, exp_stat: 16'h0029, exp_rd: 16'h007E};

      rst_n = 1'b0; wb_adr = 1'b0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
      wb_dat_w = 16'h0; wb_sel = 2'b00; sclk = 1'b1; mosi = 1'b0; ss_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset ack", {15'b0, wb_ack}, 16'h0);
      chk("reset dat_o", wb_dat_r, 16'h0);
      chk("reset miso/oe/irq", {13'b0, miso, miso_oe, irq}, 16'h0004);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      wb_read(1'b1, d);
      chk("reset status", d, 16'h0008);

      // Single-byte exchanges
      foreach (vecs[k]) begin
         wb_write(1'b0, {8'hEE, vecs[k].tx}, 2'b01);
         spi_sel();
         chk($sformatf("v%0d oe", k), {15'b0, miso_oe}, 16'h0001);
         spi_shift(vecs[k].mosi, 8, r);
         spi_desel();
         chk($sformatf("v%0d miso", k), {8'h0, r}, {8'h0, vecs[k].exp_miso});
         wb_read(1'b1, d);
         chk($sformatf("v%0d status", k), d, vecs[k].exp_stat);
         wb_read(1'b0, d);
         chk($sformatf("v%0d data", k), d, vecs[k].exp_rd);
      end

      // Underrun: no TX byte queued
      wb_write(1'b1, 16'h0002, 2'b01);
      wb_read(1'b1, d);
      chk("underrun cleared", d, 16'h0008);
      spi_sel();
      spi_shift(8'h12, 8, r);
      spi_desel();
      chk("underrun miso idle", {8'h0, r}, 16'h00FF);
      wb_read(1'b1, d);
      chk("underrun status", d, 16'h0029);
      wb_write(1'b1, 16'h0002, 2'b01);
      wb_read(1'b1, d);
      chk("underrun clear", d, 16'h0009);
      wb_read(1'b0, d);
      chk("underrun data", d, 16'h0012);

      // Overrun: RX_DEPTH+1 bytes in one select
      spi_sel();
      for (int i = 1; i <= 5; i++) spi_shift(8'(i * 16), 8, r);
      spi_desel();
      wb_read(1'b1, d);
      chk("overrun status", d, 16'h002F);
      for (int i = 1; i <= 4; i++) begin
         wb_read(1'b0, d);
         chk($sformatf("overrun data%0d", i), d, 16'(i * 16));
      end
      wb_read(1'b1, d);
      chk("overrun drained", d, 16'h002C);
      wb_read(1'b0, d);
      chk("empty read", d, 16'h0000);
      wb_write(1'b1, 16'h0003, 2'b01);
      wb_read(1'b1, d);
      chk("flags cleared", d, 16'h0008);

      // Aborted byte after 5 bits, then a full byte
      spi_sel();
      spi_shift(8'hAA, 5, r);
      spi_desel();
      chk("abort oe/miso", {14'b0, miso_oe, miso}, 16'h0001);
      wb_read(1'b1, d);
      chk("abort status", d, 16'h0028);
      spi_sel();
      spi_shift(8'h81, 8, r);
      spi_desel();
      wb_read(1'b0, d);
      chk("abort data", d, 16'h0081);
      wb_read(1'b1, d);
      chk("abort only one", {15'b0, d[0]}, 16'h0000);

      // Interrupt
      wb_write(1'b1, 16'h0103, 2'b11);
      wb_read(1'b1, d);
`ifdef WB_SPI_SLAVE_IRQ_EN
      chk("irq_en status", d, 16'h0108);
`else
      chk("irq_en status", d, 16'h0008);
`endif
      chk("irq idle", {15'b0, irq}, 16'h0000);
      spi_sel();
      spi_shift(8'h77, 8, r);
      spi_desel();
`ifdef WB_SPI_SLAVE_IRQ_EN
      chk("irq raised", {15'b0, irq}, 16'h0001);
`else
      chk("irq tied", {15'b0, irq}, 16'h0000);
`endif
      wb_read(1'b0, d);
      chk("irq data", d, 16'h0077);
      repeat (2) @(negedge clk);
      chk("irq dropped", {15'b0, irq}, 16'h0000);

      // Reset mid-byte
      wb_write(1'b0, 16'h0000, 2'b01);
      spi_sel();
      spi_shift(8'hF0, 3, r);
      chk("pre-reset miso", {15'b0, miso}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid reset outputs", {12'b0, wb_ack, miso, miso_oe, irq}, 16'h0004);
      chk("mid reset dat_o", wb_dat_r, 16'h0000);
      ss_n = 1'b1; sclk = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wb_read(1'b1, d);
      chk("post reset status", d, 16'h0008);
      wb_write(1'b0, 16'h006B, 2'b01);
      spi_sel();
      spi_shift(8'h3C, 8, r);
      spi_desel();
      chk("post reset miso", {8'h0, r}, 16'h006B);
      wb_read(1'b0, d);
      chk("post reset data", d, 16'h003C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
